// File: rtl/switches_pkg.sv
// Shared constants for the four-channel switch debounce / LED toggle block.
//   NUM_SWITCHES            : number of independent switch channels
//   DEBOUNCE_CYCLES_DEFAULT : stable clocks needed to accept a level (10 ms at 25 MHz)
package switches_pkg;

    localparam int unsigned NUM_SWITCHES            = 4;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/switch_debounce.sv
// Single-channel switch debouncer: 2-flop synchronizer, stability counter,
// debounced level register and a one-cycle release pulse.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   switch_raw in   raw bouncing switch level (1 = pressed)
//   level      out  debounced switch level (registered)
//   rel_pulse  out  one-cycle pulse on an accepted 1->0 transition (registered)
//   fall_c     out  combinational strobe, high in the cycle whose edge accepts a 1->0
//                   transition; lets the parent update state on the same edge as level
module switch_debounce
    import switches_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic switch_raw,
    output logic level,
    output logic rel_pulse,
    output logic fall_c
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             mismatch_c;
    logic             accept_c;

    // Two-flop synchronizer; sync[1] is the only copy of the input used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], switch_raw};
        end
    end

    always_comb begin
        mismatch_c = sync[1] ^ level;
        accept_c   = mismatch_c && (cnt == CNT_MAX);
        fall_c     = accept_c && level;
    end

    // Counter only runs while the synchronized level disagrees with the accepted
    // one; it saturates at CNT_MAX because acceptance clears it on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            level     <= 1'b0;
            rel_pulse <= 1'b0;
        end else begin
            rel_pulse <= fall_c;
            if (!mismatch_c) begin
                cnt <= '0;
            end else if (accept_c) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce_toggle.sv
// Four independent debounced switches, each toggling its LED on release.
// Ports:
//   i_clk                 in   clock, rising edge
//   i_rst                 in   asynchronous active-high reset
//   i_switch_1..4         in   raw bouncing switch levels (1 = pressed)
//   o_led_1..4            out  toggle state per channel
//   o_sw_db[3:0]          out  debounced levels, bit n-1 = channel n
//   o_release[3:0]        out  one-cycle pulse per channel on accepted release
module switch_debounce_toggle
    import switches_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_switch_1,
    input  logic       i_switch_2,
    input  logic       i_switch_3,
    input  logic       i_switch_4,
    output logic       o_led_1,
    output logic       o_led_2,
    output logic       o_led_3,
    output logic       o_led_4,
    output logic [3:0] o_sw_db,
    output logic [3:0] o_release
);

    logic [NUM_SWITCHES-1:0] sw_raw;
    logic [NUM_SWITCHES-1:0] fall_c;
    logic [NUM_SWITCHES-1:0] led;

    assign sw_raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

    // One debouncer per channel; channels share nothing but clock and reset.
    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_chan
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (i_clk),
            .rst        (i_rst),
            .switch_raw (sw_raw[g]),
            .level      (o_sw_db[g]),
            .rel_pulse  (o_release[g]),
            .fall_c     (fall_c[g])
        );
    end

    // Toggle registers flip on the same edge the debounced level falls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            led <= '0;
        end else begin
            led <= led ^ fall_c;
        end
    end

    assign o_led_1 = led[0];
    assign o_led_2 = led[1];
    assign o_led_3 = led[2];
    assign o_led_4 = led[3];

endmodule
